// File: rtl/writeback_regfile.sv
// Writeback stage register file: eight 16-bit registers, NZP condition codes, two read ports.
// Define WB_BYPASS_EN to forward the writeback value to a read port addressing the register being written.
module writeback_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enP,
  input  logic [1:0]  W_ControlP,
  input  logic [15:0] ALUoutP,
  input  logic [15:0] MemoutP,
  input  logic [15:0] PCoutP,
  input  logic [15:0] NpcP,
  input  logic [2:0]  dr,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [15:0] wb_data,
  output logic [2:0]  psr
);

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;
  localparam logic [1:0] SEL_NPC = 2'b11;

  logic [DATA_W-1:0] regs [NREGS];

  // Condition codes are derived by treating the writeback value as signed.
  function automatic logic [2:0] nzp_of(input logic signed [DATA_W-1:0] v);
    if (v < 0)
      return 3'b100;
    else if (v == 0)
      return 3'b010;
    else
      return 3'b001;
  endfunction

  always_comb begin
    wb_data = ALUoutP;
    case (W_ControlP)
      SEL_ALU: wb_data = ALUoutP;
      SEL_MEM: wb_data = MemoutP;
      SEL_PC:  wb_data = PCoutP;
      SEL_NPC: wb_data = NpcP;
      default: wb_data = ALUoutP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (enP) begin
      regs[dr] <= wb_data;
    end
  end

  // JSR link writes (NpcP source) must not disturb the condition codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      psr <= 3'b010;
    else if (enP && (W_ControlP != SEL_NPC))
      psr <= nzp_of(wb_data);
  end

`ifdef WB_BYPASS_EN
  assign VSR1 = (enP && (sr1 == dr)) ? wb_data : regs[sr1];
  assign VSR2 = (enP && (sr2 == dr)) ? wb_data : regs[sr2];
`else
  assign VSR1 = regs[sr1];
  assign VSR2 = regs[sr2];
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed testbench for writeback_regfile with hand-computed expected values.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enP;
  logic [1:0]  W_ControlP;
  logic [15:0] ALUoutP, MemoutP, PCoutP, NpcP;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] VSR1, VSR2, wb_data;
  logic [2:0]  psr;

  int checks = 0;
  int errors = 0;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .enP(enP), .W_ControlP(W_ControlP),
    .ALUoutP(ALUoutP), .MemoutP(MemoutP), .PCoutP(PCoutP), .NpcP(NpcP),
    .dr(dr), .sr1(sr1), .sr2(sr2),
    .VSR1(VSR1), .VSR2(VSR2), .wb_data(wb_data), .psr(psr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] d, input logic [1:0] sel, input logic [15:0] v);
    enP = 1'b1; dr = d; W_ControlP = sel;
    ALUoutP = 16'h0; MemoutP = 16'h0; PCoutP = 16'h0; NpcP = 16'h0;
    case (sel)
      2'b00: ALUoutP = v;
      2'b01: MemoutP = v;
      2'b10: PCoutP  = v;
      default: NpcP  = v;
    endcase
  endtask

  initial begin
    rst_n = 1'b0; enP = 1'b0; W_ControlP = 2'b00;
    ALUoutP = 16'h0; MemoutP = 16'h0; PCoutP = 16'h0; NpcP = 16'h0;
    dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0;
    repeat (2) tick();
    check("reset_r0", VSR1, 16'h0000);
    check("reset_psr", {13'h0, psr}, 16'h0002);
    @(negedge clk); rst_n = 1'b1;

    // Write R3, then assert reset mid-cycle with a write still pending
    wr(3'd3, 2'b00, 16'h1234); sr1 = 3'd3;
    tick();
    check("pre_reset_r3", VSR1, 16'h1234);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_r3", VSR1, 16'h0000);
    check("async_reset_psr", {13'h0, psr}, 16'h0002);
    tick();
    check("reset_wins_r3", VSR1, 16'h0000);
    @(negedge clk); rst_n = 1'b1; enP = 1'b0;
    tick();
    check("post_release_r3", VSR1, 16'h0000);
    check("post_release_psr", {13'h0, psr}, 16'h0002);

    // Source select into R5
    sr1 = 3'd5;
    wr(3'd5, 2'b00, 16'h0005); #1;
    check("wb_data_alu", wb_data, 16'h0005);
    tick();
    check("sel_alu_r5", VSR1, 16'h0005);
    check("sel_alu_psr", {13'h0, psr}, 16'h0001);
    wr(3'd5, 2'b01, 16'h8000); #1;
    check("wb_data_mem", wb_data, 16'h8000);
    tick();
    check("sel_mem_r5", VSR1, 16'h8000);
    check("sel_mem_psr", {13'h0, psr}, 16'h0004);
    wr(3'd5, 2'b10, 16'h0000); tick();
    check("sel_pc_r5", VSR1, 16'h0000);
    check("sel_pc_psr", {13'h0, psr}, 16'h0002);
    wr(3'd5, 2'b11, 16'h3001); #1;
    check("wb_data_npc", wb_data, 16'h3001);
    tick();
    check("sel_npc_r5", VSR1, 16'h3001);
    check("sel_npc_psr", {13'h0, psr}, 16'h0002);

    // Disabled write must not change R2 or psr
    wr(3'd2, 2'b00, 16'h1357); sr1 = 3'd2; tick();
    check("r2_preload", VSR1, 16'h1357);
    enP = 1'b0; dr = 3'd2; MemoutP = 16'hFFFF; W_ControlP = 2'b01;
    repeat (3) tick();
    check("disabled_r2", VSR1, 16'h1357);
    check("disabled_psr", {13'h0, psr}, 16'h0001);

    // Dual read
    wr(3'd1, 2'b00, 16'hAAAA); tick();
    wr(3'd6, 2'b00, 16'h5555); tick();
    enP = 1'b0; sr1 = 3'd1; sr2 = 3'd6; #1;
    check("dual_vsr1", VSR1, 16'hAAAA);
    check("dual_vsr2", VSR2, 16'h5555);
    sr1 = 3'd6; #1;
    check("same_vsr1", VSR1, 16'h5555);
    check("same_vsr2", VSR2, 16'h5555);

    // Read during write to R4
    sr1 = 3'd4; sr2 = 3'd6;
    wr(3'd4, 2'b00, 16'h0042); #1;
`ifdef WB_BYPASS_EN
    check("bypass_pre_vsr1", VSR1, 16'h0042);
`else
    check("nobypass_pre_vsr1", VSR1, 16'h0000);
`endif
    check("bypass_other_vsr2", VSR2, 16'h5555);
    tick();
    enP = 1'b0; #1;
    check("bypass_post_vsr1", VSR1, 16'h0042);

    // R0 is an ordinary register
    sr1 = 3'd0;
    wr(3'd0, 2'b00, 16'hBEEF); tick();
    check("r0_write", VSR1, 16'hBEEF);

    // Back-to-back writes to R7
    sr1 = 3'd7;
    wr(3'd7, 2'b00, 16'h0001); tick();
    check("b2b_first_r7", VSR1, 16'h0001);
    check("b2b_first_psr", {13'h0, psr}, 16'h0001);
    wr(3'd7, 2'b00, 16'hFFFF); tick();
    enP = 1'b0; #1;
    check("b2b_second_r7", VSR1, 16'hFFFF);
    check("b2b_second_psr", {13'h0, psr}, 16'h0004);

    // Other registers keep their values
    sr1 = 3'd1; sr2 = 3'd5; #1;
    check("keep_r1", VSR1, 16'hAAAA);
    check("keep_r5", VSR2, 16'h3001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
